spi_xfer_seq: RTL and testbench
===============================

Name: spi_xfer_seq

Overview:
Multi-byte SPI transaction sequencer that sits directly upstream of spi_ctrl. It accepts a transfer command (byte count and bit order) plus a stream of TX bytes, and drives spi_ctrl's select, exchange and send-data inputs one byte at a time. It collects each received byte into an RX FIFO. Chip select stays asserted for the whole burst, with programmable setup and hold gaps.

Parameters:
BYTE, 8, data width per exchange; must match spi_ctrl BYTE.
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; power of two, at least 2.
LEN_W, 8, width of the byte-count field; maximum burst is 2^LEN_W-1 bytes.
CS_SETUP, 2, clk_i cycles between select assertion and the first exchange pulse; at least 1.
CS_HOLD, 2, clk_i cycles between the last ready and select deassertion; at least 1.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  command strobe; accepted only in IDLE
len_i  in  LEN_W  bytes to exchange; sampled with start_i
msb_lsb_sel_i  in  1  bit order; sampled with start_i
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle pulse at end of transfer
tx_data_i  in  BYTE  TX byte
tx_valid_i  in  1  TX byte valid
tx_ready_o  out  1  TX FIFO not full
rx_data_o  out  BYTE  head of RX FIFO
rx_valid_o  out  1  RX FIFO not empty
rx_ready_i  in  1  pop RX FIFO when rx_valid_o is high
spi_select_o  out  1  to spi_ctrl spi_select_i; low means CS asserted
spi_msb_lsb_sel_o  out  1  to spi_ctrl spi_msb_lsb_sel_i
spi_exchange_o  out  1  to spi_ctrl spi_exchange_i; one-cycle pulse
spi_send_data_o  out  BYTE  to spi_ctrl spi_send_data_i
spi_busy_i  in  1  from spi_ctrl spi_busy_o
spi_ready_i  in  1  from spi_ctrl spi_ready_o; one-cycle pulse, recv data valid
spi_recv_data_i  in  BYTE  from spi_ctrl spi_recv_data_o

Behaviour:
- Reset (rst_i high at a clk_i edge) sets:
  - busy_o=0, done_o=0, spi_exchange_o=0, spi_select_o=1, spi_msb_lsb_sel_o=0, spi_send_data_o=0.
  - Both FIFOs empty, so tx_ready_o=1 and rx_valid_o=0. The FSM goes to IDLE and the counters clear.
  - Reset mid-burst aborts immediately: select deasserts at the reset edge, there is no done_o, and FIFO contents are lost.
- The FIFOs are independent of the FSM.
  - TX push occurs when tx_valid_i and tx_ready_o are both high, including in IDLE (preload allowed).
  - RX pop occurs when rx_ready_i and rx_valid_o are both high.
  - A simultaneous push and pop on a full or empty FIFO is legal: occupancy is unchanged and data order is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_data_o is registered FIFO head data with no read latency; it is valid whenever rx_valid_o is high.
- FSM states are IDLE, SETUP, LOAD, EXCH, WAIT, HOLD, DONE.
- IDLE:
  - start_i with len_i!=0: latch len and msb_lsb_sel, set busy_o=1, spi_select_o=0, and go to SETUP on the next edge.
  - start_i with len_i==0: pulse done_o for one cycle, leave select high, and stay in IDLE.
- SETUP: wait CS_SETUP cycles, then go to LOAD.
- LOAD:
  - Wait until the TX FIFO is non-empty, the RX FIFO has at least one free entry, and spi_busy_i=0.
  - Then pop one TX byte into spi_send_data_o and go to EXCH.
  - CS stays low while stalled in LOAD.
- EXCH: spi_exchange_o=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - On spi_ready_i, push spi_recv_data_i into the RX FIFO (space is guaranteed by the LOAD check) and decrement the remaining count.
  - If the count reaches 0, go to HOLD; otherwise go to LOAD.
- HOLD: wait CS_HOLD cycles, then set spi_select_o=1 and go to DONE.
- DONE: done_o=1 and busy_o=0 on the following cycle, then go to IDLE.
- spi_send_data_o and spi_msb_lsb_sel_o stay stable from EXCH until spi_ready_i.
- spi_ready_i outside WAIT is ignored and nothing is pushed.
- start_i outside IDLE is ignored.
- The minimum per-byte gap between an accepted ready and the next exchange pulse is 2 cycles (LOAD, EXCH).

Test Plan:
- Preload TX 0xA5,0x3C, then start with len=2, msb=1. Model returns 0x5A,0xC3. Required: select low for the whole burst; exactly 2 exchange pulses; RX delivers 0x5A then 0xC3; done_o pulses once; select high CS_HOLD cycles after the 2nd ready.
- start with len=0 → done_o pulses the next cycle; select never goes low; no exchange pulse.
- len=3 with TX supplied one byte every 50 cycles → sequencer stalls in LOAD with CS held low; exactly 3 exchanges; completes normally.
- FIFO_DEPTH=4, len=6, rx_ready_i held low → exactly 4 exchanges and then a stall. Raise rx_ready_i → the remaining 2 exchanges proceed; RX order is preserved.
- rst_i asserted during WAIT of byte 2 → select_o=1, busy_o=0, rx_valid_o=0 after the edge; no done_o. A new start works normally afterwards.
- Fill TX (4 pushes), then push and pop simultaneously during a burst → tx_ready_o stays 0 while full; no lost or duplicated bytes; the second start_i pulse issued during the burst is ignored.

Source files
------------

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: multi-byte SPI burst sequencer placed in front of spi_ctrl.
// A command (byte count + bit order) opens a burst: chip select is pulled low,
// TX bytes are handed to spi_ctrl one at a time, every received byte is queued
// in the RX FIFO, and select is released after a hold gap.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, len_i,
//   msb_lsb_sel_i           command strobe, byte count, bit order (IDLE only)
//   busy_o, done_o          burst in progress / one-cycle end-of-burst pulse
//   tx_data_i/valid_i/ready_o   TX byte stream into the TX FIFO
//   rx_data_o/valid_o/ready_i   RX byte stream out of the RX FIFO
//   spi_*                   connection to spi_ctrl
//   dbg_state               current FSM state (state_t encoding)
//
// Handshakes: a byte moves on a clock edge where valid and ready are both
// high. tx_ready_o depends only on TX FIFO occupancy and rx_valid_o only on
// RX FIFO occupancy, so neither depends combinationally on the partner's
// valid/ready.
module spi_xfer_seq #(
    parameter int BYTE       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             msb_lsb_sel_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic [BYTE-1:0]  tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [BYTE-1:0]  rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             spi_select_o,
    output logic             spi_msb_lsb_sel_o,
    output logic             spi_exchange_o,
    output logic [BYTE-1:0]  spi_send_data_o,
    input  logic             spi_busy_i,
    input  logic             spi_ready_i,
    input  logic [BYTE-1:0]  spi_recv_data_i,
    output logic [2:0]       dbg_state
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int GMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int GW   = $clog2(GMAX + 1);
    localparam logic [CW-1:0] FULL       = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] SETUP_LAST = GW'(CS_SETUP - 1);
    localparam logic [GW-1:0] HOLD_LAST  = GW'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOAD, S_EXCH, S_WAIT, S_HOLD, S_DONE
    } state_t;

    state_t state_q, state_d;

    // ---------------- TX FIFO ----------------
    logic [BYTE-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0]   tx_wr_q, tx_rd_q;
    logic [CW-1:0]   tx_cnt_q;
    logic            tx_push, tx_pop;

    assign tx_ready_o = (tx_cnt_q != FULL);
    assign tx_push    = tx_valid_i && tx_ready_o;

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_q] <= tx_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [BYTE-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]   rx_wr_q, rx_rd_q;
    logic [CW-1:0]   rx_cnt_q;
    logic            rx_push, rx_pop;

    assign rx_valid_o = (rx_cnt_q != '0);
    assign rx_pop     = rx_ready_i && rx_valid_o;
    assign rx_data_o  = rx_mem[rx_rd_q];

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr_q] <= spi_recv_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
                default: rx_cnt_q <= rx_cnt_q;
            endcase
        end
    end

    // ---------------- Sequencer ----------------
    logic [GW-1:0]    gap_q;
    logic [LEN_W-1:0] remain_q;
    logic             msb_q;
    logic [BYTE-1:0]  send_q;
    logic             zero_done_q;
    logic             accept, zero_start;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        zero_start = 1'b0;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        accept  = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            S_SETUP: if (gap_q == SETUP_LAST) state_d = S_LOAD;
            S_LOAD: begin
                // Reserving RX space here is what lets WAIT push unconditionally.
                if ((tx_cnt_q != '0) && (rx_cnt_q != FULL) && !spi_busy_i) begin
                    tx_pop  = 1'b1;
                    state_d = S_EXCH;
                end
            end
            S_EXCH: state_d = S_WAIT;
            S_WAIT: begin
                if (spi_ready_i) begin
                    rx_push = 1'b1;
                    state_d = (remain_q == LEN_W'(1)) ? S_HOLD : S_LOAD;
                end
            end
            S_HOLD: if (gap_q == HOLD_LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gap_q       <= '0;
            remain_q    <= '0;
            msb_q       <= 1'b0;
            send_q      <= '0;
            zero_done_q <= 1'b0;
        end else begin
            // Gap counter runs only while dwelling in SETUP or HOLD.
            gap_q <= ((state_d == state_q) && ((state_q == S_SETUP) || (state_q == S_HOLD)))
                     ? gap_q + 1'b1 : '0;
            zero_done_q <= zero_start;
            if (accept) begin
                remain_q <= len_i;
                msb_q    <= msb_lsb_sel_i;
            end else if (rx_push) begin
                remain_q <= remain_q - 1'b1;
            end
            if (tx_pop) send_q <= tx_mem[tx_rd_q];
        end
    end

    // Outputs decode the registered state, so they change only on clock edges.
    assign spi_select_o      = !((state_q == S_SETUP) || (state_q == S_LOAD) || (state_q == S_EXCH) ||
                                 (state_q == S_WAIT)  || (state_q == S_HOLD));
    assign busy_o            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o            = (state_q == S_DONE) || zero_done_q;
    assign spi_exchange_o    = (state_q == S_EXCH);
    assign spi_send_data_o   = send_q;
    assign spi_msb_lsb_sel_o = msb_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Testbench for spi_xfer_seq: clock/reset, a behavioural spi_ctrl model that
// returns the nibble-swapped send byte, driver tasks, a negedge monitor with
// an RX scoreboard queue, scenario tasks and a final report.
module tb_spi_xfer_seq;

    localparam int BYTE = 8, DEPTH = 4, LEN_W = 8, CS_SETUP = 2, CS_HOLD = 2;
    localparam int MDL_LAT = 8;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd2, ST_WAIT = 3'd4;

    logic             clk = 1'b0, rst = 1'b1;
    logic             start = 1'b0, msb = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done;
    logic [BYTE-1:0]  tx_data = '0;
    logic             tx_valid = 1'b0, tx_ready;
    logic [BYTE-1:0]  rx_data;
    logic             rx_valid, rx_ready = 1'b0;
    logic             spi_select, spi_msb, spi_exch;
    logic [BYTE-1:0]  spi_send;
    logic             spi_busy = 1'b0, spi_ready = 1'b0;
    logic [BYTE-1:0]  spi_recv = '0;
    logic [2:0]       dbg_state;

    int n_checks = 0, n_fail = 0, cyc = 0;
    logic [BYTE-1:0] exp_q[$];
    logic [BYTE-1:0] sent_q[$];
    logic [BYTE-1:0] mdl_data = '0;
    int   exch_cnt = 0, done_cnt = 0, glitch_cnt = 0;
    int   ready_cyc = 0, sel_fall_cyc = 0, sel_rise_cyc = 0, first_exch_cyc = 0;
    logic prev_sel = 1'b1, prev_exch = 1'b0, exp_msb = 1'b0, first_pending = 1'b0;

    spi_xfer_seq #(.BYTE(BYTE), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W),
                   .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .msb_lsb_sel_i(msb),
        .busy_o(busy), .done_o(done),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .spi_select_o(spi_select), .spi_msb_lsb_sel_o(spi_msb), .spi_exchange_o(spi_exch),
        .spi_send_data_o(spi_send), .spi_busy_i(spi_busy), .spi_ready_i(spi_ready),
        .spi_recv_data_i(spi_recv), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BYTE-1:0] swap(input logic [BYTE-1:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    // ---------------- spi_ctrl model ----------------
    initial begin
        int lat;
        lat = 0;
        forever begin
            @(posedge clk); #1;
            spi_ready = 1'b0;
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    spi_busy  = 1'b0;
                    spi_ready = 1'b1;
                    spi_recv  = swap(mdl_data);
                end
            end else if (spi_exch) begin
                spi_busy = 1'b1;
                mdl_data = spi_send;
                lat      = MDL_LAT;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (spi_exch) begin
                exch_cnt++;
                if (first_pending) begin
                    first_exch_cyc = cyc;
                    first_pending  = 1'b0;
                end
                n_checks++;
                if (prev_exch !== 1'b0) begin
                    n_fail++; $display("FAIL exch_width: exchange high two cycles in a row");
                end
                n_checks++;
                if (spi_select !== 1'b0) begin
                    n_fail++; $display("FAIL exch_select: select=%b want 0", spi_select);
                end
                n_checks++;
                if (sent_q.size() == 0) begin
                    n_fail++; $display("FAIL exch_unexpected: exchange with no TX byte outstanding");
                end else begin
                    logic [BYTE-1:0] e;
                    e = sent_q.pop_front();
                    if (spi_send !== e) begin
                        n_fail++; $display("FAIL exch_data: got %h want %h", spi_send, e);
                    end
                end
                n_checks++;
                if (spi_msb !== exp_msb) begin
                    n_fail++; $display("FAIL exch_msb: got %b want %b", spi_msb, exp_msb);
                end
            end
            if (spi_ready && busy) begin
                ready_cyc = cyc;
                n_checks++;
                if (spi_send !== mdl_data) begin
                    n_fail++; $display("FAIL send_stable: got %h want %h", spi_send, mdl_data);
                end
            end
            if (done) done_cnt++;
            if (busy && spi_select) glitch_cnt++;
            if (!spi_select && prev_sel) sel_fall_cyc = cyc;
            if (spi_select && !prev_sel) sel_rise_cyc = cyc;
            if (rx_valid && rx_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rx_unexpected: got %h, nothing expected", rx_data);
                end else begin
                    logic [BYTE-1:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        n_fail++; $display("FAIL rx_data: got %h want %h", rx_data, e);
                    end
                end
            end
        end
        prev_sel  = spi_select;
        prev_exch = spi_exch;
    end

    // ---------------- driver tasks (enter/leave just after posedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [BYTE-1:0] b);
        int t;
        logic ok;
        t = 0; ok = 1'b0;
        tx_data = b; tx_valid = 1'b1;
        while (!ok && t < 3000) begin
            @(negedge clk);
            if (tx_ready) ok = 1'b1;
            else begin @(posedge clk); #1; end
            t++;
        end
        if (ok) begin
            sent_q.push_back(b);
            exp_q.push_back(swap(b));
        end else begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: tx_ready stayed 0 for byte %h", b);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic start_xfer(input int l, input logic m, input logic accepted);
        start = 1'b1; len = LEN_W'(l); msb = m;
        if (accepted) begin
            exp_msb = m; first_pending = 1'b1;
        end
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int t;
        logic got;
        t = 0; got = 1'b0;
        while (!got && t < budget) begin
            @(negedge clk);
            if (done) got = 1'b1;
            t++;
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        n_checks += 8;
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (spi_exch !== 1'b0)   begin n_fail++; $display("FAIL reset_exch: got %b want 0", spi_exch); end
        if (spi_select !== 1'b1) begin n_fail++; $display("FAIL reset_select: got %b want 1", spi_select); end
        if (spi_msb !== 1'b0)    begin n_fail++; $display("FAIL reset_msb: got %b want 0", spi_msb); end
        if (spi_send !== 8'h00)  begin n_fail++; $display("FAIL reset_send: got %h want 00", spi_send); end
        if (tx_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        if (rx_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int b_ex, b_dn;
        rx_ready = 1'b1; b_ex = exch_cnt; b_dn = done_cnt; glitch_cnt = 0;
        push_tx(8'hA5);
        push_tx(8'h3C);
        start_xfer(2, 1'b1, 1'b1);
        wait_done("basic", 400);
        tick(5);
        n_checks += 6;
        if (exch_cnt - b_ex != 2) begin n_fail++; $display("FAIL basic_exch: got %0d want 2", exch_cnt - b_ex); end
        if (done_cnt - b_dn != 1) begin n_fail++; $display("FAIL basic_done: got %0d want 1", done_cnt - b_dn); end
        if (glitch_cnt != 0)      begin n_fail++; $display("FAIL basic_cs: select high while busy %0d cycles want 0", glitch_cnt); end
        if (sel_rise_cyc - ready_cyc != CS_HOLD + 1)
            begin n_fail++; $display("FAIL basic_hold: got %0d want %0d", sel_rise_cyc - ready_cyc, CS_HOLD + 1); end
        if (first_exch_cyc - sel_fall_cyc != CS_SETUP + 1)
            begin n_fail++; $display("FAIL basic_setup: got %0d want %0d", first_exch_cyc - sel_fall_cyc, CS_SETUP + 1); end
        if (exp_q.size() != 0)    begin n_fail++; $display("FAIL basic_rx_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_zero_len();
        int b_ex, b_dn, hi;
        b_ex = exch_cnt; b_dn = done_cnt; hi = 0;
        start_xfer(0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (spi_select === 1'b1 && busy === 1'b0) hi++;
        end
        @(posedge clk); #1;
        n_checks += 3;
        if (hi != 6)              begin n_fail++; $display("FAIL zero_idle: got %0d idle cycles want 6", hi); end
        if (exch_cnt != b_ex)     begin n_fail++; $display("FAIL zero_exch: got %0d want 0", exch_cnt - b_ex); end
        if (done_cnt - b_dn != 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt - b_dn); end
    endtask

    task automatic test_stall();
        int b_ex;
        rx_ready = 1'b1; b_ex = exch_cnt;
        start_xfer(3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(49);
            @(negedge clk);
            n_checks += 3;
            if (dbg_state !== ST_LOAD) begin n_fail++; $display("FAIL stall_state%0d: got %0d want %0d", i, dbg_state, ST_LOAD); end
            if (spi_select !== 1'b0)   begin n_fail++; $display("FAIL stall_cs%0d: got %b want 0", i, spi_select); end
            if (exch_cnt - b_ex != i)  begin n_fail++; $display("FAIL stall_exch%0d: got %0d want %0d", i, exch_cnt - b_ex, i); end
            @(posedge clk); #1;
            push_tx(8'($urandom_range(0, 255)));
        end
        wait_done("stall", 400);
        tick(3);
        n_checks++;
        if (exch_cnt - b_ex != 3) begin n_fail++; $display("FAIL stall_total: got %0d want 3", exch_cnt - b_ex); end
    endtask

    task automatic test_rx_backpressure();
        int b_ex;
        rx_ready = 1'b0; b_ex = exch_cnt;
        start_xfer(6, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) push_tx(8'($urandom_range(0, 255)));
        tick(200);
        @(negedge clk);
        n_checks += 4;
        if (exch_cnt - b_ex != DEPTH) begin n_fail++; $display("FAIL bp_exch: got %0d want %0d", exch_cnt - b_ex, DEPTH); end
        if (rx_valid !== 1'b1)        begin n_fail++; $display("FAIL bp_rx_valid: got %b want 1", rx_valid); end
        if (dbg_state !== ST_LOAD)    begin n_fail++; $display("FAIL bp_state: got %0d want %0d", dbg_state, ST_LOAD); end
        if (spi_select !== 1'b0)      begin n_fail++; $display("FAIL bp_cs: got %b want 0", spi_select); end
        @(posedge clk); #1;
        rx_ready = 1'b1;
        wait_done("bp", 600);
        tick(3);
        n_checks += 2;
        if (exch_cnt - b_ex != 6) begin n_fail++; $display("FAIL bp_total: got %0d want 6", exch_cnt - b_ex); end
        if (exp_q.size() != 0)    begin n_fail++; $display("FAIL bp_rx_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int b_ex, b_dn, t;
        rx_ready = 1'b1; b_ex = exch_cnt; b_dn = done_cnt; t = 0;
        for (int i = 0; i < 3; i++) push_tx(8'($urandom_range(0, 255)));
        start_xfer(3, 1'b0, 1'b1);
        while (exch_cnt - b_ex < 2 && t < 500) begin @(negedge clk); t++; end
        n_checks++;
        if (exch_cnt - b_ex < 2) begin n_fail++; $display("FAIL rmid_timeout: got %0d exchanges want 2", exch_cnt - b_ex); end
        @(posedge clk); #1;
        tick(2);
        @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL rmid_state: got %0d want %0d", dbg_state, ST_WAIT); end
        @(posedge clk); #1;
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        n_checks += 4;
        if (spi_select !== 1'b1) begin n_fail++; $display("FAIL rmid_select: got %b want 1", spi_select); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        if (rx_valid !== 1'b0)   begin n_fail++; $display("FAIL rmid_rx_valid: got %b want 0", rx_valid); end
        if (tx_ready !== 1'b1)   begin n_fail++; $display("FAIL rmid_tx_ready: got %b want 1", tx_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        sent_q.delete();
        tick(30);
        n_checks++;
        if (done_cnt != b_dn) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - b_dn); end
        b_dn = done_cnt;
        push_tx(8'h81);
        start_xfer(1, 1'b1, 1'b1);
        wait_done("rmid_restart", 400);
        tick(3);
        n_checks += 2;
        if (done_cnt - b_dn != 1) begin n_fail++; $display("FAIL rmid_restart_done: got %0d want 1", done_cnt - b_dn); end
        if (exp_q.size() != 0)    begin n_fail++; $display("FAIL rmid_rx_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int b_ex, b_dn, full_cnt;
        rx_ready = 1'b1; b_ex = exch_cnt; b_dn = done_cnt; full_cnt = 0;
        for (int i = 0; i < DEPTH; i++) push_tx(8'(8'h10 + i));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b0) full_cnt++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (full_cnt != 3) begin n_fail++; $display("FAIL b2b_full: tx_ready low %0d cycles want 3", full_cnt); end
        start_xfer(8, 1'b0, 1'b1);
        push_tx(8'($urandom_range(0, 255)));
        start_xfer(2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) push_tx(8'($urandom_range(0, 255)));
        wait_done("b2b", 800);
        tick(60);
        n_checks += 5;
        if (exch_cnt - b_ex != 8) begin n_fail++; $display("FAIL b2b_exch: got %0d want 8", exch_cnt - b_ex); end
        if (done_cnt - b_dn != 1) begin n_fail++; $display("FAIL b2b_done: got %0d want 1", done_cnt - b_dn); end
        if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL b2b_state: got %0d want %0d", dbg_state, ST_IDLE); end
        if (exp_q.size() != 0)    begin n_fail++; $display("FAIL b2b_rx_left: got %0d want 0", exp_q.size()); end
        if (sent_q.size() != 0)   begin n_fail++; $display("FAIL b2b_tx_left: got %0d want 0", sent_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_rx_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
